// File: rtl/rriot_timer_if.sv
// rriot_timer_if -- CPU-side register access bundle for the RRIOT interval timer.
//
// Signals:
//   sel     timer register access this cycle (chip select, I/O space, timer decode)
//   we_n    0 = write, 1 = read (qualified by sel)
//   addr    A3 = IRQ enable, A1:A0 = divider select on writes, A0 = count/flag select on reads
//   di      write data
//   dout    read data (combinational)
//   irq     active-low interrupt level for the PB7 pin
//   irq_en  1 = PB7 carries the interrupt
//
// Modports: master = CPU/bus side, slave = timer side.
`timescale 1ns/1ps
interface rriot_timer_if;
  logic       sel;
  logic       we_n;
  logic [3:0] addr;
  logic [7:0] di;
  logic [7:0] dout;
  logic       irq;
  logic       irq_en;

  modport master (output sel, we_n, addr, di, input dout, irq, irq_en);
  modport slave  (input sel, we_n, addr, di, output dout, irq, irq_en);
endinterface

// File: rtl/rriot_timer.sv
// rriot_timer -- 6530/6532-style interval timer with 1/8/64/1024 prescaler.
//
// Ports:
//   phi2  system clock, all state updates on the rising edge
//   rst   asynchronous active-high reset
//   bus   rriot_timer_if.slave: sel, we_n, addr, di in; dout, irq, irq_en out
//
// Behaviour summary: a write loads the 8-bit count and selects a divider;
// in LOAD mode the count steps once per divider period. Decrementing past
// 0x00 sets the flag and switches to EXPIRED mode, where the count runs
// down every cycle. Reading the count clears the flag and returns to LOAD.
//
// Configuration macro: RRIOT_TIMER_IRQ_EN
//   defined   -> ien register exists; irq = ~(flag & ien), irq_en = ien
//   undefined -> no ien register; irq tied high, irq_en tied low
//                (the flag stays readable through the status read)
`timescale 1ns/1ps
module rriot_timer (
  input  logic          phi2,
  input  logic          rst,
  rriot_timer_if.slave  bus
);

  typedef enum logic {LOAD = 1'b0, EXPIRED = 1'b1} mode_t;

  logic [7:0] count;
  logic [9:0] prescaler;
  logic [9:0] div_m1;
  logic       flag;
  mode_t      mode;

  logic       wr;
  logic       rd_cnt;
  logic       tick;
  logic       underflow;
  logic [7:0] dout_c;

  // Divider select: A1:A0 -> divide by 1, 8, 64, 1024 (stored minus one).
  function automatic logic [9:0] div_lookup(input logic [1:0] sel_bits);
    logic [9:0] v;
    case (sel_bits)
      2'b00:   v = 10'd0;
      2'b01:   v = 10'd7;
      2'b10:   v = 10'd63;
      default: v = 10'd1023;
    endcase
    return v;
  endfunction

  assign wr     = bus.sel & ~bus.we_n;
  assign rd_cnt = bus.sel &  bus.we_n & ~bus.addr[0];

  // In EXPIRED mode the count moves every cycle; in LOAD mode only when
  // the prescaler has run out.
  assign tick      = (mode == EXPIRED) | (prescaler == 10'd0);
  // Only a LOAD-mode wrap counts as an underflow; free-running wraps in
  // EXPIRED mode leave the flag alone. A write on the same edge wins.
  assign underflow = ~wr & (mode == LOAD) & (prescaler == 10'd0) & (count == 8'h00);

  always_ff @(posedge phi2 or posedge rst) begin
    if (rst) begin
      count     <= 8'hFF;
      prescaler <= 10'd0;
      div_m1    <= 10'd0;
      flag      <= 1'b0;
      mode      <= EXPIRED;
    end else if (wr) begin
      count     <= bus.di;
      div_m1    <= div_lookup(bus.addr[1:0]);
      prescaler <= div_lookup(bus.addr[1:0]);
      flag      <= 1'b0;
      mode      <= LOAD;
    end else begin
      if (tick)
        count <= count - 8'd1;

      if (mode == EXPIRED)
        prescaler <= 10'd0;
      else if (prescaler == 10'd0)
        prescaler <= div_m1;
      else
        prescaler <= prescaler - 10'd1;

      // Count read acknowledges the interrupt and restarts the divider.
      if (rd_cnt) begin
        flag      <= 1'b0;
        mode      <= LOAD;
        prescaler <= div_m1;
      end

      // Placed last so a coincident underflow beats the count read.
      if (underflow) begin
        flag <= 1'b1;
        mode <= EXPIRED;
      end
    end
  end

  // Read mux; forced to zero while in reset or when not selected.
  always_comb begin
    dout_c = 8'h00;
    if (!rst && bus.sel && bus.we_n) begin
      if (bus.addr[0])
        dout_c = {flag, 7'b0};
      else
        dout_c = count;
    end
  end

  assign bus.dout = dout_c;

`ifdef RRIOT_TIMER_IRQ_EN
  logic ien;

  always_ff @(posedge phi2 or posedge rst) begin
    if (rst)
      ien <= 1'b0;
    else if (wr || rd_cnt)
      ien <= bus.addr[3];
  end

  assign bus.irq    = ~(flag & ien);
  assign bus.irq_en = ien;
`else
  assign bus.irq    = 1'b1;
  assign bus.irq_en = 1'b0;
`endif

  // A2 is not decoded by the timer; A3 only matters with the IRQ option.
  logic unused_addr;
  assign unused_addr = &{1'b0, bus.addr[3:2]};

endmodule

// File: tb/tb_rriot_timer.sv
`timescale 1ns/1ps
module tb_rriot_timer;

  logic phi2 = 1'b0;
  logic rst  = 1'b1;

  rriot_timer_if bus();

  rriot_timer dut (
    .phi2 (phi2),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 phi2 = ~phi2;

`ifdef RRIOT_TIMER_IRQ_EN
  localparam bit FEAT = 1'b1;
`else
  localparam bit FEAT = 1'b0;
`endif

  int n_vec = 0;
  int n_err = 0;

  // ---------------- checking helpers ----------------
  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic e_irq(input bit flag_and_ien);
    return FEAT ? ~flag_and_ien : 1'b1;
  endfunction

  function automatic logic e_irqen(input bit ien);
    return FEAT ? ien : 1'b0;
  endfunction

  task automatic chk_irq(input string nm, input bit fi, input bit ie);
    chk8({nm, "_irq"},    {7'b0, bus.irq},    {7'b0, e_irq(fi)});
    chk8({nm, "_irq_en"}, {7'b0, bus.irq_en}, {7'b0, e_irqen(ie)});
  endtask

  task automatic drive(input logic s, input logic w, input logic [3:0] a, input logic [7:0] d);
    bus.sel  = s;
    bus.we_n = w;
    bus.addr = a;
    bus.di   = d;
  endtask

  // Look at dout between edges without letting a read reach a clock edge.
  task automatic peek(input string nm, input logic [3:0] a, input logic [7:0] exp);
    drive(1'b1, 1'b1, a, 8'h00);
    #1;
    chk8(nm, bus.dout, exp);
    drive(1'b0, 1'b1, 4'h0, 8'h00);
  endtask

  // One clocked operation; returns 1ns after the edge with the bus idle.
  task automatic step(input logic s, input logic w, input logic [3:0] a, input logic [7:0] d);
    drive(s, w, a, d);
    @(posedge phi2);
    #1;
    drive(1'b0, 1'b1, 4'h0, 8'h00);
  endtask

  task automatic step_rd(input string nm, input logic [3:0] a, input logic [7:0] exp);
    drive(1'b1, 1'b1, a, 8'h00);
    #1;
    chk8(nm, bus.dout, exp);
    @(posedge phi2);
    #1;
    drive(1'b0, 1'b1, 4'h0, 8'h00);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 4'h0, 8'h00);
  endtask

  // ---------------- reference model ----------------
  // Timer viewed as: count value, cycles left before the next LOAD-mode
  // step, the chosen period, and whether it is free-running after expiry.
  int divs[4] = '{0, 7, 63, 1023};
  int m_count, m_wait, m_period;
  bit m_flag, m_ien, m_exp;

  task automatic model_reset();
    m_count = 255; m_wait = 0; m_period = 0;
    m_flag = 0; m_ien = 0; m_exp = 1;
  endtask

  task automatic model_step(input logic s, input logic w, input logic [3:0] a, input logic [7:0] d);
    bit wr, rc, uf;
    wr = s && !w;
    rc = s && w && !a[0];
    uf = 0;
    if (wr) begin
      m_count  = int'(d);
      m_period = divs[a[1:0]];
      m_wait   = m_period;
      m_flag   = 0;
      m_ien    = a[3];
      m_exp    = 0;
    end else begin
      if (m_exp || m_wait == 0) begin
        if (!m_exp && m_count == 0) uf = 1;
        m_count = (m_count + 255) % 256;
      end
      if (!m_exp) m_wait = (m_wait == 0) ? m_period : m_wait - 1;
      if (rc) begin
        m_flag = 0; m_ien = a[3]; m_exp = 0; m_wait = m_period;
      end
      if (uf) begin
        m_flag = 1; m_exp = 1;
      end
    end
  endtask

  function automatic logic [7:0] m_dout(input logic s, input logic w, input logic [3:0] a);
    if (!s || !w) return 8'h00;
    if (a[0]) return {m_flag, 7'b0};
    return 8'(m_count);
  endfunction

  // ---------------- directed table ----------------
  typedef struct {
    logic       s;
    logic       w;
    logic [3:0] a;
    logic [7:0] d;
    logic       cd;   // check dout
    logic [7:0] ed;
    logic       fi;   // flag & ien before the edge
    logic       ie;   // ien before the edge
  } vec_t;

  vec_t tbl[16];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b0, 1'b1, 4'h0, 8'h00);

    // ---- reset state ----
    #1;
    chk_irq("rst_hold", 1'b0, 1'b0);
    peek("rst_dout_cnt", 4'h0, 8'h00);
    peek("rst_dout_flag", 4'h1, 8'h00);
    @(posedge phi2);
    @(posedge phi2);
    #1;
    rst = 1'b0;
    peek("rst_count", 4'h0, 8'hFF);
    peek("rst_flag", 4'h1, 8'h00);

    // ---- table: divide-by-1 count-down, underflow, acknowledge ----
    tbl[0]  = '{1'b1, 1'b0, 4'h0, 8'h03, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 4'h0, 8'h00, 1'b1, 8'h03, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 4'h0, 8'h00, 1'b1, 8'h02, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 4'h0, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 4'h0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 4'h1, 8'h00, 1'b1, 8'h80, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 4'h0, 8'h00, 1'b1, 8'hFE, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 4'h1, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 4'h3, 8'hAA, 1'b1, 8'h00, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 4'h0, 8'h00, 1'b1, 8'hFB, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 4'h8, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 4'h9, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1};
    tbl[12] = '{1'b1, 1'b1, 4'h9, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1};
    tbl[13] = '{1'b1, 1'b1, 4'h9, 8'h00, 1'b1, 8'h80, 1'b1, 1'b1};
    tbl[14] = '{1'b1, 1'b1, 4'h0, 8'h00, 1'b1, 8'hFE, 1'b1, 1'b1};
    tbl[15] = '{1'b1, 1'b1, 4'h1, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0};

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].s, tbl[i].w, tbl[i].a, tbl[i].d);
      #1;
      if (tbl[i].cd) chk8($sformatf("tbl%0d_dout", i), bus.dout, tbl[i].ed);
      chk_irq($sformatf("tbl%0d", i), tbl[i].fi, tbl[i].ie);
      @(posedge phi2);
      #1;
      drive(1'b0, 1'b1, 4'h0, 8'h00);
    end

    // ---- divide by 8 with IRQ enabled ----
    step(1'b1, 1'b0, 4'h9, 8'h02);
    for (int i = 1; i <= 23; i++) begin
      step(1'b0, 1'b1, 4'h0, 8'h00);
      if (i % 8 == 0 || i == 23) begin
        peek($sformatf("div8_cnt%0d", i), 4'h0, 8'(2 - i / 8));
        peek($sformatf("div8_flag%0d", i), 4'h1, 8'h00);
      end
    end
    step(1'b0, 1'b1, 4'h0, 8'h00);
    peek("div8_uf_flag", 4'h1, 8'h80);
    chk_irq("div8_uf", 1'b1, 1'b1);
    drive(1'b1, 1'b1, 4'h1, 8'h00);
    #1;
    chk_irq("stat_rd", 1'b1, 1'b1);
    chk8("stat_rd_dout", bus.dout, 8'h80);
    @(posedge phi2);
    #1;
    drive(1'b0, 1'b1, 4'h0, 8'h00);
    chk_irq("after_stat_rd", 1'b1, 1'b1);
    step_rd("ack_rd_dout", 4'h8, 8'hFE);
    chk_irq("after_ack", 1'b0, 1'b1);
    peek("after_ack_flag", 4'h1, 8'h00);

    // ---- divide by 1024 ----
    step(1'b1, 1'b0, 4'h3, 8'h01);
    idle(1023);
    peek("div1024_hold", 4'h0, 8'h01);
    idle(1);
    peek("div1024_step", 4'h0, 8'h00);
    idle(1023);
    peek("div1024_pre_uf", 4'h1, 8'h00);
    idle(1);
    peek("div1024_uf_cnt", 4'h0, 8'hFF);
    peek("div1024_uf_flag", 4'h1, 8'h80);

    // ---- write coincident with underflow ----
    step(1'b1, 1'b0, 4'h0, 8'h01);
    idle(1);
    peek("coin_wr_pre", 4'h0, 8'h00);
    step(1'b1, 1'b0, 4'h0, 8'h55);
    peek("coin_wr_cnt", 4'h0, 8'h55);
    peek("coin_wr_flag", 4'h1, 8'h00);

    // ---- count read coincident with underflow (di = 0x00, div 8) ----
    step(1'b1, 1'b0, 4'h1, 8'h00);
    idle(7);
    peek("coin_rd_pre", 4'h1, 8'h00);
    step_rd("coin_rd_dout", 4'h0, 8'h00);
    peek("coin_rd_flag", 4'h1, 8'h80);
    peek("coin_rd_cnt", 4'h0, 8'hFF);
    idle(1);
    peek("coin_rd_expired", 4'h0, 8'hFE);

    // ---- reset mid-count with divide by 64 ----
    step(1'b1, 1'b0, 4'hA, 8'h01);
    idle(30);
    rst = 1'b1;
    #1;
    peek("rst_mid_dout", 4'h0, 8'h00);
    chk_irq("rst_mid", 1'b0, 1'b0);
    @(negedge phi2);
    rst = 1'b0;
    peek("rst_mid_cnt", 4'h0, 8'hFF);
    peek("rst_mid_flag", 4'h1, 8'h00);
    @(posedge phi2);
    #1;
    peek("rst_resume", 4'h0, 8'hFE);

    // reset after an interrupt is pending: irq must release at once
    step(1'b1, 1'b0, 4'hA, 8'h01);
    idle(128);
    peek("rst_irq_flag", 4'h1, 8'h80);
    chk_irq("rst_irq_pend", 1'b1, 1'b1);
    rst = 1'b1;
    #1;
    chk_irq("rst_irq_async", 1'b0, 1'b0);
    peek("rst_irq_dout", 4'h1, 8'h00);
    @(posedge phi2);
    #1;
    rst = 1'b0;

    // ---- randomized run against the reference model ----
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [3:0] pa;
      logic       s, w;
      logic [3:0] a;
      logic [7:0] d;
      int         r;
      pa = 4'($urandom_range(0, 15));
      peek($sformatf("rnd%0d_peek", c), pa, m_dout(1'b1, 1'b1, pa));
      r = $urandom_range(0, 99);
      a = 4'($urandom_range(0, 15));
      d = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 4));
      if (r < 4)       begin s = 1'b1; w = 1'b0; end
      else if (r < 12) begin s = 1'b1; w = 1'b1; a[0] = 1'b0; end
      else if (r < 20) begin s = 1'b1; w = 1'b1; a[0] = 1'b1; end
      else             begin s = 1'b0; w = 1'($urandom); end
      if (r < 4 && $urandom_range(0, 3) != 0) a[1] = 1'b0;
      drive(s, w, a, d);
      #1;
      if (!(s && !w)) chk8($sformatf("rnd%0d_dout", c), bus.dout, m_dout(s, w, a));
      chk_irq($sformatf("rnd%0d", c), m_flag && m_ien, m_ien);
      @(posedge phi2);
      model_step(s, w, a, d);
      #1;
      drive(1'b0, 1'b1, 4'h0, 8'h00);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
